// File: rtl/scan_crypt_pkg.sv
// Shared types and sizing helpers for the encrypted scan-chain sequencer.
package scan_crypt_pkg;

  localparam int DEF_CHAIN_LEN = 128;
  localparam int DEF_PAT_W     = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEY_START,
    ST_KEY_WAIT,
    ST_SHIFT,
    ST_UPDATE,
    ST_CAPTURE,
    ST_FINISH
  } state_e;

  // Index width for a counter covering 0..n-1, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scan_crypt_seq_ctrl_bit_counter.sv
// Position counter for one SHIFT window: clear wins over enable, wraps after CHAIN_LEN-1.
// tc is decoded from the registered count, no backpressure.
module scan_bit_counter
  import scan_crypt_pkg::*;
#(
  parameter int CHAIN_LEN = DEF_CHAIN_LEN
) (
  input  logic                         tck,
  input  logic                         reset_n,
  input  logic                         clr,
  input  logic                         en,
  output logic [idx_w(CHAIN_LEN)-1:0]  cnt,
  output logic                         tc
);

  localparam int               CNT_W = idx_w(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CHAIN_LEN - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge tck) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == LAST);

endmodule

// File: rtl/scan_crypt_seq_ctrl.sv
// Key-expansion launch plus overlapped SHIFT/UPDATE/CAPTURE sequencing for the encrypted scan chain.
// Moore outputs from registered state; optional KEY_WAIT timeout under SCAN_KEY_TIMEOUT_EN.
module scan_crypt_seq_ctrl
  import scan_crypt_pkg::*;
#(
  parameter int CHAIN_LEN   = DEF_CHAIN_LEN,
  parameter int PAT_W       = DEF_PAT_W,
  parameter int KEY_TIMEOUT = 64
) (
  input  logic                         tck,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic [PAT_W-1:0]             num_patterns,
  input  logic                         key_done,
  output logic                         ka_start,
  output logic                         shift_en,
  output logic                         update_en,
  output logic                         capture_en,
  output logic                         si_req,
  output logic                         so_valid,
  output logic [idx_w(CHAIN_LEN)-1:0]  bit_idx,
  output logic [PAT_W-1:0]             pat_idx,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   num_q, num_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic               cnt_clr;
  logic               cnt_en;
  logic               cnt_tc;
  logic               start_ok;

`ifdef SCAN_KEY_TIMEOUT_EN
  localparam int             KT_W = idx_w(KEY_TIMEOUT);
  localparam logic [KT_W-1:0] KT_LAST = KT_W'(KEY_TIMEOUT - 1);

  logic [KT_W-1:0] kt_q, kt_d;
  logic            err_q, err_d;
`endif

  scan_bit_counter #(
    .CHAIN_LEN (CHAIN_LEN)
  ) u_bit_cnt (
    .tck     (tck),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .cnt     (bit_idx),
    .tc      (cnt_tc)
  );

  // abort beats a coincident start, so it never launches a run
  assign start_ok = (state_q == ST_IDLE) && start && !abort;
  assign cnt_en   = (state_q == ST_SHIFT);
  assign cnt_clr  = (state_q != ST_SHIFT) || abort;

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    pat_d   = pat_q;
`ifdef SCAN_KEY_TIMEOUT_EN
    err_d   = err_q;
    kt_d    = (state_q == ST_KEY_WAIT) ? kt_q + KT_W'(1) : '0;
`endif

    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            num_d   = num_patterns;
            pat_d   = '0;
`ifdef SCAN_KEY_TIMEOUT_EN
            err_d   = 1'b0;
`endif
            state_d = (num_patterns == '0) ? ST_FINISH : ST_KEY_START;
          end
        end
        ST_KEY_START: state_d = ST_KEY_WAIT;
        ST_KEY_WAIT: begin
          if (key_done) begin
            state_d = ST_SHIFT;
          end
`ifdef SCAN_KEY_TIMEOUT_EN
          else if (kt_q == KT_LAST) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
`endif
        end
        ST_SHIFT: begin
          if (cnt_tc) begin
            state_d = (pat_q == num_q) ? ST_FINISH : ST_UPDATE;
          end
        end
        ST_UPDATE: state_d = ST_CAPTURE;
        ST_CAPTURE: begin
          pat_d   = pat_q + PAT_W'(1);
          state_d = ST_SHIFT;
        end
        ST_FINISH: state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge tck) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      num_q   <= '0;
      pat_q   <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      pat_q   <= pat_d;
    end
  end

`ifdef SCAN_KEY_TIMEOUT_EN
  always_ff @(posedge tck) begin
    if (!reset_n) begin
      kt_q  <= '0;
      err_q <= 1'b0;
    end else begin
      kt_q  <= kt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Window 0 only loads, the final window only unloads, all others overlap both.
  assign busy       = (state_q != ST_IDLE);
  assign ka_start   = (state_q == ST_KEY_START);
  assign shift_en   = (state_q == ST_SHIFT);
  assign update_en  = (state_q == ST_UPDATE);
  assign capture_en = (state_q == ST_CAPTURE);
  assign done       = (state_q == ST_FINISH);
  assign si_req     = shift_en && (pat_q < num_q);
  assign so_valid   = shift_en && (pat_q != '0);
  assign pat_idx    = pat_q;

endmodule

// File: tb/tb_scan_crypt_seq_ctrl.sv
// Scoreboard bench for scan_crypt_seq_ctrl: stimulus queues expected enable/done events with cycle stamps.
module tb_scan_crypt_seq_ctrl;
  import scan_crypt_pkg::*;

  localparam int CL = 128;
  localparam int PW = 16;
  localparam int BW = idx_w(CL);
  localparam int BIG = 32'h7fff_ffff;

  logic          tck = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [PW-1:0] num_patterns = '0;
  logic          key_done = 1'b0;
  logic          ka_start, shift_en, update_en, capture_en, si_req, so_valid;
  logic [BW-1:0] bit_idx;
  logic [PW-1:0] pat_idx;
  logic          busy, done, err;

  scan_crypt_seq_ctrl #(.CHAIN_LEN(CL), .PAT_W(PW), .KEY_TIMEOUT(64)) dut (
    .tck(tck), .reset_n(reset_n), .start(start), .abort(abort),
    .num_patterns(num_patterns), .key_done(key_done), .ka_start(ka_start),
    .shift_en(shift_en), .update_en(update_en), .capture_en(capture_en),
    .si_req(si_req), .so_valid(so_valid), .bit_idx(bit_idx), .pat_idx(pat_idx),
    .busy(busy), .done(done), .err(err)
  );

  always #5 tck = ~tck;

  int cyc = 0;
  always @(posedge tck) cyc <= cyc + 1;

  typedef struct packed {
    logic [4:0]    kind;
    logic          si;
    logic          so;
    logic [BW-1:0] bidx;
    logic [PW-1:0] pat;
    logic [31:0]   cyc;
  } tok_t;

  localparam logic [4:0] K_KA = 5'b10000;
  localparam logic [4:0] K_SH = 5'b01000;
  localparam logic [4:0] K_UP = 5'b00100;
  localparam logic [4:0] K_CA = 5'b00010;
  localparam logic [4:0] K_DN = 5'b00001;

  tok_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic tok_t mk(input logic [4:0] kind, input logic si, input logic so,
                              input int b, input int p, input int c);
    tok_t t;
    t.kind = kind;
    t.si   = si;
    t.so   = so;
    t.bidx = BW'(b);
    t.pat  = PW'(p);
    t.cyc  = 32'(c);
    return t;
  endfunction

  // Expected events of a run accepted at cycle k whose first SHIFT is at s0; nothing after stop.
  task automatic push_run(input int k, input int s0, input int n, input int stop);
    int t;
    if (n == 0) begin
      if (k + 1 <= stop) exp_q.push_back(mk(K_DN, 1'b0, 1'b0, 0, 0, k + 1));
      return;
    end
    if (k + 1 <= stop) exp_q.push_back(mk(K_KA, 1'b0, 1'b0, 0, 0, k + 1));
    t = s0;
    for (int w = 0; w <= n; w++) begin
      for (int b = 0; b < CL; b++) begin
        if (t <= stop) exp_q.push_back(mk(K_SH, (w < n), (w > 0), b, w, t));
        t++;
      end
      if (w < n) begin
        if (t <= stop) exp_q.push_back(mk(K_UP, 1'b0, 1'b0, 0, w, t));
        t++;
        if (t <= stop) exp_q.push_back(mk(K_CA, 1'b0, 1'b0, 0, w, t));
        t++;
      end
    end
    if (t <= stop) exp_q.push_back(mk(K_DN, 1'b0, 1'b0, 0, n, t));
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] outs_vec();
    return {ka_start, shift_en, update_en, capture_en, done, si_req, so_valid, busy, err,
            bit_idx, pat_idx};
  endfunction

  task automatic goto(input int target);
    while (cyc < target) begin
      @(posedge tck);
      #1;
    end
  endtask

  task automatic pulse_start(input int n, output int k);
    num_patterns = PW'(n);
    start = 1'b1;
    k = cyc;
    @(posedge tck);
    #1;
    start = 1'b0;
  endtask

  // Monitor: every cycle with an active enable/done must match the head of the queue.
  tok_t act_t, exp_t;
  always @(negedge tck) begin
    act_t.kind = {ka_start, shift_en, update_en, capture_en, done};
    act_t.si   = si_req;
    act_t.so   = so_valid;
    act_t.bidx = bit_idx;
    act_t.pat  = pat_idx;
    act_t.cyc  = 32'(cyc);
    if (act_t.kind != 5'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got kind=%b pat=%0d bit=%0d at cycle %0d, expected none",
                 act_t.kind, act_t.pat, act_t.bidx, act_t.cyc);
      end else begin
        exp_t = exp_q.pop_front();
        if (act_t !== exp_t) begin
          errors++;
          $display("FAIL event: got kind=%b si=%b so=%b bit=%0d pat=%0d cyc=%0d, expected kind=%b si=%b so=%b bit=%0d pat=%0d cyc=%0d",
                   act_t.kind, act_t.si, act_t.so, act_t.bidx, act_t.pat, act_t.cyc,
                   exp_t.kind, exp_t.si, exp_t.so, exp_t.bidx, exp_t.pat, exp_t.cyc);
        end
      end
    end
  end

  always @(posedge tck) begin
    if (cyc > 30000) begin
      errors++;
      $display("FAIL watchdog: got cycle %0d, expected completion before 30000", cyc);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  initial begin
    int k, s0, stop;

    // Reset held three cycles, then idle with start low.
    repeat (3) @(posedge tck);
    #1;
    check("outs_in_reset", outs_vec(), 32'h0);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge tck);
      #1;
      check("outs_idle_after_reset", outs_vec(), 32'h0);
    end

    // One pattern, key_done ten cycles after ka_start: done 259 cycles after key_done.
    pulse_start(1, k);
    push_run(k, k + 12, 1, BIG);
    goto(k + 11);
    key_done = 1'b1;
    goto(k + 272);
    check("n1_idle_after_done", 32'(busy), 32'h0);
    check("n1_pat_retained", 32'(pat_idx), 32'h1);
    key_done = 1'b0;

    // Three patterns with a stray start mid-run that must be ignored.
    pulse_start(3, k);
    s0 = k + 6;
    push_run(k, s0, 3, BIG);
    goto(k + 5);
    key_done = 1'b1;
    goto(s0 + 20);
    num_patterns = PW'(5);
    start = 1'b1;
    @(posedge tck);
    #1;
    start = 1'b0;
    goto(s0 + 520);
    check("n3_idle_after_done", 32'(busy), 32'h0);
    check("n3_pat_retained", 32'(pat_idx), 32'h3);

    // Zero patterns: done the cycle after start, no key expansion.
    pulse_start(0, k);
    push_run(k, 0, 0, BIG);
    goto(k + 3);
    check("n0_idle", outs_vec(), 32'h0);
    key_done = 1'b0;

    // Two patterns aborted at bit 50 of the second window.
    pulse_start(2, k);
    s0 = k + 5;
    stop = s0 + CL + 2 + 50;
    push_run(k, s0, 2, stop);
    goto(k + 4);
    key_done = 1'b1;
    goto(stop);
    check("abort_at_bit50", 32'(bit_idx), 32'd50);
    abort = 1'b1;
    @(posedge tck);
    #1;
    abort = 1'b0;
    check("abort_idle_outs", outs_vec(), 32'h1);
    abort = 1'b1;
    @(posedge tck);
    #1;
    abort = 1'b0;
    check("abort_in_idle_noop", 32'(busy), 32'h0);

    // Fresh run with key_done already high: KEY_WAIT lasts one cycle.
    pulse_start(2, k);
    s0 = k + 3;
    push_run(k, s0, 2, BIG);
    goto(s0 + 3 * CL + 6);
    check("rerun_idle_after_done", 32'(busy), 32'h0);
    check("rerun_pat_retained", 32'(pat_idx), 32'h2);
    key_done = 1'b0;

`ifdef SCAN_KEY_TIMEOUT_EN
    pulse_start(1, k);
    push_run(k, k + 1000, 1, k + 1);
    goto(k + 65);
    check("kt_still_waiting", {30'b0, busy, err}, 32'h2);
    goto(k + 66);
    check("kt_timeout_err", {30'b0, busy, err}, 32'h1);
    goto(k + 70);
    pulse_start(0, k);
    push_run(k, 0, 0, BIG);
    check("kt_err_cleared", 32'(err), 32'h0);
`else
    pulse_start(1, k);
    push_run(k, k + 1000, 1, k + 1);
    goto(k + 80);
    check("kw_waits_forever", {30'b0, busy, err}, 32'h2);
    abort = 1'b1;
    @(posedge tck);
    #1;
    abort = 1'b0;
    check("kw_abort_idle", 32'(busy), 32'h0);
`endif

    goto(cyc + 3);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
